// File: rtl/ram_burst_reader.sv
// ram_burst_reader: sequential read master over a RAM read port.
// Streams `length` words from `start_addr` (wrapping) through a 2-entry FIFO.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 256,
  localparam int LB_RAM_DEPTH = $clog2(RAM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LB_RAM_DEPTH-1:0] start_addr,
  input  logic [LB_RAM_DEPTH:0]   length,
  output logic                    busy,
  output logic                    done,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  output logic [LB_RAM_DEPTH-1:0] rd_addr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [LB_RAM_DEPTH-1:0] LAST_A = LB_RAM_DEPTH'(RAM_DEPTH - 1);
  localparam logic [LB_RAM_DEPTH-1:0] ONE_A  = LB_RAM_DEPTH'(1);
  localparam logic [LB_RAM_DEPTH:0]   ONE_L  = (LB_RAM_DEPTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [LB_RAM_DEPTH-1:0] addr_q, addr_d;
  logic [LB_RAM_DEPTH:0]   rem_q, rem_d;
  logic [LB_RAM_DEPTH:0]   outst_q, outst_d;

  logic [DATA_WIDTH-1:0]   mem_q [2];
  logic                    wptr_q;
  logic                    rptr_q;
  logic [1:0]              cnt_q;

  logic rd_req;
  logic push;
  logic pop;

  // A request is only raised while a FIFO slot is guaranteed free.
  assign rd_req    = (state_q == S_READ) && (rem_q != '0) && (cnt_q != 2'd2);
  assign rd_valid  = rd_req;
  assign rd_addr   = addr_q;
  assign push      = rd_req && rd_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rptr_q];
  assign pop       = out_valid && out_ready;

  // State and burst counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      outst_q <= outst_d;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    outst_d = outst_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = S_READ;
            addr_d  = start_addr;
            rem_d   = length;
            outst_d = length;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        busy = 1'b1;
        if (pop) begin
          outst_d = outst_q - ONE_L;
        end
        if (push) begin
          addr_d = (addr_q == LAST_A) ? '0 : addr_q + ONE_A;
          rem_d  = rem_q - ONE_L;
          if (rem_q == ONE_L) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop) begin
          outst_d = outst_q - ONE_L;
          if (outst_q == ONE_L) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-entry output FIFO; simultaneous push and pop both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= rd_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: directed and random bursts against a queue model.
// Slave RAM returns ram[rd_addr]; stream words are checked in order.
module tb_ram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [8:0]  length = '0;
  logic        busy;
  logic        done;
  logic [31:0] rd_data;
  logic [7:0]  rd_addr;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [31:0] ram [256];

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit          m_active = 0;
  bit          m_done_due = 0;
  int          m_addr = 0;
  int          m_rleft = 0;
  int          m_pleft = 0;
  logic [31:0] fq[$];
  int          rd_log[$];
  logic [31:0] out_log[$];
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;

  bit manual = 1;
  int rd_pct = 100;
  int out_pct = 100;

  ram_burst_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign rd_data = ram[rd_addr];

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // random handshake driver
  always @(posedge clk) begin
    #1;
    if (!manual) begin
      rd_ready  = ($urandom_range(0, 99) < rd_pct);
      out_ready = ($urandom_range(0, 99) < out_pct);
    end
  end

  // model update and per-cycle comparison
  always @(negedge clk) begin
    bit cur_act;
    bit cur_done;
    bit nxt_done;
    bit exp_rv;
    if (rst) begin
      m_active   = 0;
      m_done_due = 0;
      m_rleft    = 0;
      m_pleft    = 0;
      fq.delete();
    end else begin
      cyc++;
      cur_act  = m_active;
      cur_done = m_done_due;
      nxt_done = 0;
      exp_rv   = cur_act && (m_rleft > 0) && (fq.size() < 2);
      chk("busy", 64'(busy), 64'(cur_act));
      chk("done", 64'(done), 64'(cur_done));
      chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
      if (rd_valid) chk("rd_addr", 64'(rd_addr), 64'(m_addr));
      chk("out_valid", 64'(out_valid), 64'(fq.size() > 0));
      if (out_valid && fq.size() > 0) chk("out_data", 64'(out_data), 64'(fq[0]));
      if (done) done_cyc = cyc;
      if (out_valid && out_ready && fq.size() > 0) begin
        out_log.push_back(fq[0]);
        void'(fq.pop_front());
        m_pleft--;
        if (m_pleft == 0 && cur_act) begin
          m_active = 0;
          nxt_done = 1;
        end
      end
      if (exp_rv && rd_ready) begin
        fq.push_back(ram[m_addr]);
        rd_log.push_back(m_addr);
        m_addr = (m_addr + 1) % 256;
        m_rleft--;
      end
      if (start && !cur_act && !cur_done) begin
        start_cyc = cyc;
        rd_log.delete();
        out_log.delete();
        if (length == 0) begin
          nxt_done = 1;
        end else begin
          m_active = 1;
          m_addr   = int'(start_addr);
          m_rleft  = int'(length);
          m_pleft  = int'(length);
        end
      end
      m_done_due = nxt_done;
    end
  end

  task automatic do_start(int a, int n);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = 8'(a);
    length     = 9'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!m_active && !m_done_due) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: burst still active after 3000 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'(i);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_ready  = 1'b1;
    out_ready = 1'b1;

    // basic burst
    do_start(8'h10, 4);
    wait_idle();
    chk("basic_nrd", 64'(rd_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
      chk("basic_addr", 64'(rd_log[i]), 64'(8'h10 + i));
      chk("basic_out", 64'(out_log[i]), 64'(8'h10 + i));
    end
    chk("basic_done_lat", 64'(done_cyc - start_cyc), 64'd6);

    // wrap-around
    do_start(8'hFE, 4);
    wait_idle();
    chk("wrap_nout", 64'(out_log.size()), 64'd4);
    if (out_log.size() == 4) begin
      chk("wrap0", 64'(out_log[0]), 64'h0FE);
      chk("wrap1", 64'(out_log[1]), 64'h0FF);
      chk("wrap2", 64'(out_log[2]), 64'h000);
      chk("wrap3", 64'(out_log[3]), 64'h001);
    end

    // backpressure
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    out_ready = 1'b0;
    do_start(8'h50, 6);
    repeat (6) @(posedge clk);
    #1;
    chk("bp_reads", 64'(rd_log.size()), 64'd2);
    chk("bp_rd_valid", 64'(rd_valid), 64'd0);
    out_ready = 1'b1;
    wait_idle();
    chk("bp_nout", 64'(out_log.size()), 64'd6);

    // slave stall on 2nd request
    do_start(8'h60, 5);
    @(negedge clk);
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stall_addr", 64'(rd_addr), 64'h61);
    chk("stall_valid", 64'(rd_valid), 64'd1);
    chk("stall_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_idle();
    chk("stall_nout", 64'(out_log.size()), 64'd5);

    // zero length
    do_start(8'h20, 0);
    wait_idle();
    chk("zero_done_lat", 64'(done_cyc - start_cyc), 64'd1);
    chk("zero_nrd", 64'(rd_log.size()), 64'd0);

    // ignored start mid-burst
    do_start(8'h40, 8);
    repeat (2) @(posedge clk);
    do_start(8'h99, 3);
    wait_idle();
    chk("ign_nrd", 64'(rd_log.size()), 64'd8);
    if (rd_log.size() > 0) chk("ign_first", 64'(rd_log[0]), 64'h40);

    // reset mid-burst
    do_start(8'h30, 8);
    for (int i = 0; i < 50 && out_log.size() < 2; i++) @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mrst_rd_addr", 64'(rd_addr), 64'd0);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_data", 64'(out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    do_start(8'h70, 5);
    wait_idle();
    chk("post_rst_nout", 64'(out_log.size()), 64'd5);
    if (rd_log.size() > 0) chk("post_rst_first", 64'(rd_log[0]), 64'h70);

    // randomized bursts
    manual = 0;
    for (int k = 0; k < 40; k++) begin
      int n;
      for (int i = 0; i < 256; i++) ram[i] = $urandom;
      rd_pct  = $urandom_range(30, 100);
      out_pct = $urandom_range(30, 100);
      n = (k % 13 == 5) ? 256 : int'($urandom_range(0, 20));
      do_start(int'($urandom_range(0, 255)), n);
      wait_idle();
      chk("rand_nout", 64'(out_log.size()), 64'(n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
